flow_led_ctrl: RTL and testbench

//   Parametrised next-generation flowing-LED driver. One lit LED moves across an
//   LED_NUM-wide bank at a programmable step rate set by an internal prescaler.

---
 rtl/flow_led_ctrl.sv | 97 +++++++++
 tb/tb_flow_led_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_led_ctrl.sv
// rtl/flow_led_ctrl.sv - prescaled flowing-LED driver: rotate left/right, bounce or hold
module flow_led_ctrl #(
    parameter int LED_NUM   = 4,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [LED_NUM-1:0]   led,
    output logic                 step
);

    localparam int POS_W = $clog2(LED_NUM);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_NUM - 1);
    localparam logic [POS_W-1:0] POS_PEN  = POS_W'(LED_NUM - 2);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    localparam logic [1:0] MODE_LEFT   = 2'b00;
    localparam logic [1:0] MODE_RIGHT  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [POS_W-1:0]     pos;
    logic [POS_W-1:0]     pos_nxt;
    logic                 dir;
    logic                 dir_nxt;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 tick;

    // >= rather than == so a div lowered below the running count ticks at once
    assign tick = en && (cnt >= div);

    assign led = LED_NUM'(1) << pos;

    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        case (mode)
            MODE_LEFT: begin
                pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_ONE;
                dir_nxt = DIR_UP;
            end
            MODE_RIGHT: begin
                pos_nxt = (pos == '0) ? POS_LAST : pos - POS_ONE;
                dir_nxt = DIR_DOWN;
            end
            MODE_BOUNCE: begin
                // turn around without relighting the end LED
                if (dir == DIR_UP) begin
                    if (pos == POS_LAST) begin
                        pos_nxt = POS_PEN;
                        dir_nxt = DIR_DOWN;
                    end else begin
                        pos_nxt = pos + POS_ONE;
                    end
                end else begin
                    if (pos == '0) begin
                        pos_nxt = POS_ONE;
                        dir_nxt = DIR_UP;
                    end else begin
                        pos_nxt = pos - POS_ONE;
                    end
                end
            end
            default: begin
                pos_nxt = pos;
                dir_nxt = dir;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos  <= '0;
            dir  <= DIR_UP;
            cnt  <= '0;
            step <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt  <= '0;
                step <= 1'b1;
                pos  <= pos_nxt;
                dir  <= dir_nxt;
            end else begin
                cnt  <= cnt + DIV_WIDTH'(1);
                step <= 1'b0;
            end
        end else begin
            step <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flow_led_ctrl.sv
// tb/tb_flow_led_ctrl.sv - self-checking bench for flow_led_ctrl with a led/step scoreboard
module tb_flow_led_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] div;
    logic [3:0]  led;
    logic        step;

    typedef struct {
        logic [3:0] led;
        logic       step;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    flow_led_ctrl #(.LED_NUM(4), .DIV_WIDTH(24)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .mode (mode),
        .div  (div),
        .led  (led),
        .step (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [3:0] l, input logic s);
        exp_t e;
        e.led  = l;
        e.step = s;
        sb.push_back(e);
    endtask

    task automatic start(input logic [1:0] m, input logic [23:0] d);
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = m;
        div   = d;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        exp_t e;
        int   cyc;
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 2'b00;
        div   = 24'd0;
        sb.delete();
        #1;
        n_checks++;
        if (led !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_led: got %b expected 0001", led);
        end
        n_checks++;
        if (step !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_step: got %b expected 0", step);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(4'b0010, 1'b1);
        push(4'b0100, 1'b1);
        push(4'b1000, 1'b1);
        push(4'b0001, 1'b1);
        push(4'b0010, 1'b1);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            n_checks++;
            if (led !== e.led || step !== e.step) begin
                n_fail++;
                $display("FAIL rotate_left_div0 cycle %0d: led=%b step=%b expected led=%b step=%b",
                         cyc, led, step, e.led, e.step);
            end
        end
    endtask

    task automatic test_prescale;
        exp_t e;
        int   cyc;
        start(2'b00, 24'd2);
        for (int k = 1; k <= 9; k++) begin
            logic [3:0] l;
            l = 4'b0001 << ((k / 3) % 4);
            push(l, (k % 3) == 0);
        end
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            n_checks++;
            if (led !== e.led || step !== e.step) begin
                n_fail++;
                $display("FAIL prescale_div2 cycle %0d: led=%b step=%b expected led=%b step=%b",
                         cyc, led, step, e.led, e.step);
            end
        end
    endtask

    task automatic test_rotate_right;
        exp_t e;
        int   cyc;
        start(2'b01, 24'd0);
        push(4'b1000, 1'b1);
        push(4'b0100, 1'b1);
        push(4'b0010, 1'b1);
        push(4'b0001, 1'b1);
        push(4'b1000, 1'b1);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            n_checks++;
            if (led !== e.led || step !== e.step) begin
                n_fail++;
                $display("FAIL rotate_right cycle %0d: led=%b step=%b expected led=%b step=%b",
                         cyc, led, step, e.led, e.step);
            end
        end
    endtask

    task automatic test_bounce;
        exp_t e;
        int   cyc;
        start(2'b10, 24'd0);
        push(4'b0010, 1'b1);
        push(4'b0100, 1'b1);
        push(4'b1000, 1'b1);
        push(4'b0100, 1'b1);
        push(4'b0010, 1'b1);
        push(4'b0001, 1'b1);
        push(4'b0010, 1'b1);
        push(4'b0100, 1'b1);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            n_checks++;
            if (led !== e.led || step !== e.step) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: led=%b step=%b expected led=%b step=%b",
                         cyc, led, step, e.led, e.step);
            end
        end
    endtask

    task automatic test_enable_freeze;
        exp_t e;
        int   cyc;
        start(2'b00, 24'd3);
        for (int k = 1; k <= 8; k++) push(4'b0001, 1'b0);
        push(4'b0010, 1'b1);
        push(4'b0010, 1'b0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            n_checks++;
            if (led !== e.led || step !== e.step) begin
                n_fail++;
                $display("FAIL enable_freeze cycle %0d: led=%b step=%b expected led=%b step=%b",
                         cyc, led, step, e.led, e.step);
            end
            if (cyc == 1) en = 1'b0;
            if (cyc == 6) en = 1'b1;
        end
    endtask

    task automatic test_div_lower;
        exp_t e;
        int   cyc;
        start(2'b00, 24'd7);
        for (int k = 1; k <= 5; k++) push(4'b0001, 1'b0);
        push(4'b0010, 1'b1);
        push(4'b0010, 1'b0);
        push(4'b0010, 1'b0);
        push(4'b0100, 1'b1);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            n_checks++;
            if (led !== e.led || step !== e.step) begin
                n_fail++;
                $display("FAIL div_lower cycle %0d: led=%b step=%b expected led=%b step=%b",
                         cyc, led, step, e.led, e.step);
            end
            if (cyc == 5) div = 24'd2;
        end
    endtask

    task automatic test_async_reset_hold;
        exp_t e;
        int   cyc;
        start(2'b00, 24'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (led !== 4'b0100) begin
            n_fail++;
            $display("FAIL pre_reset_led: got %b expected 0100", led);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led !== 4'b0001 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: led=%b step=%b expected led=0001 step=0", led, step);
        end
        mode = 2'b11;
        div  = 24'd1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) push(4'b0001, (k % 2) == 0);
        cyc = 0;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            cyc++;
            e = sb.pop_front();
            n_checks++;
            if (led !== e.led || step !== e.step) begin
                n_fail++;
                $display("FAIL hold_rate cycle %0d: led=%b step=%b expected led=%b step=%b",
                         cyc, led, step, e.led, e.step);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 2'b00;
        div      = 24'd0;
        test_reset();
        test_prescale();
        test_rotate_right();
        test_bounce();
        test_enable_freeze();
        test_div_lower();
        test_async_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
